// File: rtl/rolling_key_arbiter.sv
//==============================================================================
// Module  : rolling_key_arbiter
// Shared rolling-key arbiter: lowest-index grant on key match, wait timeout
// with nack, lockout and release handshake. Define ROLLKEY_UP_EN for an
// up-counting key that resets to zero.
// Revision: 1.0
//==============================================================================
`default_nettype none

module rolling_key_arbiter #(
  parameter int KEY_W    = 4,
  parameter int NUM_CH   = 4,
  parameter int MAX_WAIT = 32,
  parameter int LOCK_CYC = 8
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [NUM_CH-1:0]       req,
  input  logic [NUM_CH*KEY_W-1:0] req_key,
  output logic [NUM_CH-1:0]       ack,
  output logic [NUM_CH-1:0]       nack,
  output logic [KEY_W-1:0]        key_cur,
  output logic                    busy
);

  localparam int c_WCNT_W = $clog2(MAX_WAIT);
  localparam int c_LCNT_W = (LOCK_CYC > 1) ? $clog2(LOCK_CYC) : 1;
  localparam logic [c_WCNT_W-1:0] c_WAIT_LAST = c_WCNT_W'(MAX_WAIT - 1);
  localparam logic [c_LCNT_W-1:0] c_LOCK_LAST = c_LCNT_W'(LOCK_CYC - 1);

  localparam logic [1:0] c_ST_IDLE    = 2'd0;
  localparam logic [1:0] c_ST_WAIT    = 2'd1;
  localparam logic [1:0] c_ST_RELEASE = 2'd2;
  localparam logic [1:0] c_ST_LOCK    = 2'd3;

  logic [KEY_W-1:0]    r_key;
  logic [KEY_W-1:0]    w_key_next;
  logic [1:0]          r_state    [NUM_CH];
  logic [c_WCNT_W-1:0] r_wait_cnt [NUM_CH];
  logic [c_LCNT_W-1:0] r_lock_cnt [NUM_CH];
  logic [NUM_CH-1:0]   r_ack;
  logic [NUM_CH-1:0]   r_nack;
  logic [NUM_CH-1:0]   w_cand;
  logic [NUM_CH-1:0]   w_grant;
  logic [NUM_CH-1:0]   w_in_wait;

`ifdef ROLLKEY_UP_EN
  localparam logic [KEY_W-1:0] c_KEY_RST = {KEY_W{1'b0}};
  assign w_key_next = r_key + KEY_W'(1);
`else
  localparam logic [KEY_W-1:0] c_KEY_RST = {KEY_W{1'b1}};
  assign w_key_next = r_key - KEY_W'(1);
`endif

  always_comb begin
    w_cand    = '0;
    w_in_wait = '0;
    for (int i = 0; i < NUM_CH; i++) begin
      w_cand[i]    = ((r_state[i] == c_ST_IDLE) || (r_state[i] == c_ST_WAIT)) &&
                     req[i] && (req_key[i*KEY_W +: KEY_W] == r_key);
      w_in_wait[i] = (r_state[i] == c_ST_WAIT);
    end
  end

  // Isolate the lowest set candidate bit: one grant per cycle, lowest index wins.
  assign w_grant = w_cand & (~w_cand + NUM_CH'(1));

  always_ff @(posedge clk) begin
    if (rst) begin
      r_key  <= c_KEY_RST;
      r_ack  <= '0;
      r_nack <= '0;
      for (int i = 0; i < NUM_CH; i++) begin
        r_state[i]    <= c_ST_IDLE;
        r_wait_cnt[i] <= '0;
        r_lock_cnt[i] <= '0;
      end
    end else begin
      r_key  <= w_key_next;
      r_ack  <= w_grant;
      r_nack <= '0;
      for (int i = 0; i < NUM_CH; i++) begin
        case (r_state[i])
          c_ST_IDLE: begin
            if (w_grant[i]) begin
              r_state[i] <= c_ST_RELEASE;
            end else if (req[i]) begin
              r_state[i]    <= c_ST_WAIT;
              r_wait_cnt[i] <= c_WCNT_W'(1);
            end
          end
          c_ST_WAIT: begin
            // Grant beats abort, abort beats timeout.
            if (w_grant[i]) begin
              r_state[i] <= c_ST_RELEASE;
            end else if (!req[i]) begin
              r_state[i] <= c_ST_IDLE;
            end else if (r_wait_cnt[i] == c_WAIT_LAST) begin
              r_state[i]    <= c_ST_LOCK;
              r_lock_cnt[i] <= '0;
              r_nack[i]     <= 1'b1;
            end else begin
              r_wait_cnt[i] <= r_wait_cnt[i] + c_WCNT_W'(1);
            end
          end
          c_ST_LOCK: begin
            if (r_lock_cnt[i] == c_LOCK_LAST) begin
              r_state[i] <= c_ST_RELEASE;
            end else begin
              r_lock_cnt[i] <= r_lock_cnt[i] + c_LCNT_W'(1);
            end
          end
          c_ST_RELEASE: begin
            if (!req[i]) begin
              r_state[i] <= c_ST_IDLE;
            end
          end
          default: r_state[i] <= c_ST_IDLE;
        endcase
      end
    end
  end

  assign ack     = r_ack;
  assign nack    = r_nack;
  assign key_cur = r_key;
  assign busy    = |w_in_wait;

endmodule

`default_nettype wire
